prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 135 +++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Serial program loader: parses a length-prefixed byte stream into 16-bit words,
// writes them to program memory and verifies a trailing XOR checksum.
module prog_loader #(
    parameter logic [9:0]  BASE_ADDR = 10'd0,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [9:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [10:0] word_count
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned CNT_W  = 11;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   len_full;
    logic [BYTE_W-1:0]  data_hi;
    logic [BYTE_W-1:0]  acc;
    logic [CNT_W-1:0]   wc_inc;
    logic               xfer;
    logic               start_ok;

    function automatic logic is_rx(input state_t s);
        return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DATA_HI) ||
               (s == S_DATA_LO) || (s == S_CHK);
    endfunction

    function automatic logic is_rest(input state_t s);
        return (s == S_IDLE) || (s == S_DONE) || (s == S_ERR);
    endfunction

    // Next-state decode; byte_ready is registered from the same state so it gates xfer exactly.
    always_comb begin
        state_nxt = state;
        xfer      = byte_valid & byte_ready;
        start_ok  = is_rest(state) & start;
        len_full  = {len[LEN_W-1:BYTE_W], byte_in};
        wc_inc    = word_count + CNT_W'(1);
        case (state)
            S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_LEN_HI;
            S_LEN_HI:  if (xfer) state_nxt = S_LEN_LO;
            S_LEN_LO: begin
                if (xfer) begin
                    if (len_full == LEN_W'(0))
                        state_nxt = S_CHK;
                    else if (32'(len_full) > MAX_WORDS)
                        state_nxt = S_ERR;
                    else
                        state_nxt = S_DATA_HI;
                end
            end
            S_DATA_HI: if (xfer) state_nxt = S_DATA_LO;
            S_DATA_LO: if (xfer) state_nxt = S_WRITE;
            S_WRITE:   state_nxt = (LEN_W'(wc_inc) == len) ? S_CHK : S_DATA_HI;
            S_CHK:     if (xfer) state_nxt = (byte_in == acc) ? S_DONE : S_ERR;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // State, datapath and status outputs, all registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            len        <= '0;
            data_hi    <= '0;
            acc        <= '0;
            byte_ready <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
        end else begin
            state      <= state_nxt;
            byte_ready <= is_rx(state_nxt);
            busy       <= !is_rest(state_nxt);
            done       <= (state_nxt == S_DONE);
            error      <= (state_nxt == S_ERR);
            wr_en      <= (state_nxt == S_WRITE);
            if (start_ok) begin
                word_count <= '0;
                acc        <= '0;
            end
            case (state)
                S_LEN_HI: if (xfer) len[LEN_W-1:BYTE_W] <= byte_in;
                S_LEN_LO: if (xfer) len[BYTE_W-1:0] <= byte_in;
                S_DATA_HI: begin
                    if (xfer) begin
                        data_hi <= byte_in;
                        acc     <= acc ^ byte_in;
                    end
                end
                // Address and data change only together with the write strobe.
                S_DATA_LO: begin
                    if (xfer) begin
                        wr_data <= {data_hi, byte_in};
                        wr_addr <= BASE_ADDR + word_count[ADDR_W-1:0];
                        acc     <= acc ^ byte_in;
                    end
                end
                S_WRITE: word_count <= wc_inc;
                default: ;
            endcase
        end
    end

endmodule
